hetic_irq_sequencer: RTL and testbench
======================================

Name: hetic_irq_sequencer

Overview:
Core-side responder for the interrupt controller's request/claim interface. It consumes the arbitrated interrupt (valid, id, level, heti, nest), decides eligibility against the current handler level and nesting state, and performs the take handshake with the core. It then returns the claim (irq_ack_o plus irq_id_o) to the controller. It keeps a LIFO of interrupted-handler contexts so nested interrupts restore the correct level on trap return.

Parameters:
NrIrqLines, 64, number of interrupt lines; IrqWidth = $clog2(NrIrqLines) (localparam)
NrIrqPrios, 32, number of priority levels; PrioWidth = $clog2(NrIrqPrios) (localparam)
NestDepth, 4, maximum simultaneously active handlers (stack entries); DepthWidth = $clog2(NestDepth+1) (localparam)

Ports:
clk_i  in  1  clock; single clock domain
rst_ni  in  1  reset, asynchronous, active-low
irq_valid_i  in  1  controller has an enabled, pending interrupt
irq_id_i  in  IrqWidth  id of arbitrated interrupt
irq_level_i  in  PrioWidth  priority of arbitrated interrupt
irq_heti_i  in  1  heti attribute of arbitrated interrupt
irq_nest_i  in  1  nest attribute of arbitrated interrupt
irq_ack_o  out  1  claim pulse to controller (clears pending)
irq_id_o  out  IrqWidth  id being claimed; valid while irq_ack_o=1
global_ie_i  in  1  core global interrupt enable
core_ready_i  in  1  core at an interruptible boundary
trap_done_i  in  1  one-cycle pulse: current handler executed return
take_o  out  1  request core to trap
take_id_o  out  IrqWidth  id for the trap (vector index)
take_heti_o  out  1  heti attribute of the trap
cur_level_o  out  PrioWidth  level of the running handler (0 = thread level)
depth_o  out  DepthWidth  number of active handlers
underflow_o  out  1  sticky: trap_done_i received at depth 0

Behaviour:
- Reset (async assert, sync-deassert assumed upstream): state=IDLE, depth=0, cur_level=0, cur_nest=1, stack cleared, all outputs 0, underflow_o=0.
- eligible = irq_valid_i & global_ie_i & ~trap_done_i & (depth<NestDepth) & (irq_level_i > cur_level) & (depth==0 | cur_nest). Level-0 interrupts are never taken; an equal level never preempts.
- FSM states: IDLE, ACK, SETTLE.
- IDLE:
  - take_o = eligible (combinational). take_id_o and take_heti_o mirror irq_id_i and irq_heti_i.
  - When take_o & core_ready_i:
    - push {cur_level, cur_nest} onto the stack.
    - cur_level <= irq_level_i; cur_nest <= irq_nest_i; depth++.
    - latch irq_id_i into id_q; go to ACK.
- ACK (1 cycle): irq_ack_o=1, irq_id_o=id_q, take_o=0; go to SETTLE.
- SETTLE (1 cycle): take_o=0; go to IDLE.
  - This cycle lets the controller's pending clear and arbiter output propagate, so the same line is never taken twice.
- Claim latency: take handshake at cycle N -> irq_ack_o at N+1 -> earliest next take_o at N+3.
- trap_done_i is accepted in any state:
  - depth>0: pop; cur_level and cur_nest <= top entry; depth--.
  - depth==0: no state change; underflow_o <= 1 (sticky until reset).
- A trap_done_i in the same cycle as a potential take suppresses the take (see eligible). The take is re-evaluated next cycle against the restored level.
- trap_done_i during ACK/SETTLE pops normally; the ACK/SETTLE sequence still completes.
- Stack full (depth==NestDepth): no take regardless of level; the interrupt stays pending at the controller.
- Reset asserted mid-ACK: irq_ack_o drops immediately (async). The claim is lost and the line stays pending, which is the accepted behaviour.
- All comparisons are unsigned on PrioWidth bits. depth never exceeds NestDepth and never goes below 0.

Decomposition:
- hetic_pkg holds:
  - irq_frame_t packed {level[PrioWidth], nest}
  - state enum {IDLE, ACK, SETTLE}
  - shared width helper constants
- Sub-module irq_nest_stack: parameterised LIFO (Depth, frame type width) with push/pop/top/count, async active-low reset.

Test Plan:
- Basic take: irq_valid=1, id=5, level=3, ie=1, core_ready=1 at cycle N -> take_o=1 at N; irq_ack_o=1 with irq_id_o=5 at N+1; cur_level_o=3, depth_o=1.
- Nested preempt: in handler level 3 with nest=1, present id=9 level=7 -> taken, depth_o=2, cur_level_o=7; trap_done_i -> cur_level_o=3, depth_o=1; second trap_done_i -> cur_level_o=0, depth_o=0.
- No-nest / equal level: in handler level 3 with nest=0, present level=7 -> take_o stays 0; in handler with nest=1, present level=3 -> take_o stays 0.
- Stack full: NestDepth=4, four nested takes at levels 1,2,3,4, present level 5 -> take_o=0 until trap_done_i, then level 5 is taken.
- Simultaneous / underflow: trap_done_i with an eligible irq in the same cycle -> no take that cycle, take next cycle if still eligible; trap_done_i at depth 0 -> underflow_o=1, depth_o stays 0.
- Reset mid-ACK: assert rst_ni=0 during the ACK cycle -> irq_ack_o=0 immediately; after release depth_o=0, cur_level_o=0, take_o re-asserts for the still-pending line.

Source files
------------

// File: rtl/hetic_pkg.sv
// Shared types and default sizing for the interrupt sequencer.
package hetic_pkg;

    localparam int unsigned DefIrqLines  = 64;
    localparam int unsigned DefIrqPrios  = 32;
    localparam int unsigned DefNestDepth = 4;
    localparam int unsigned PkgPrioWidth = $clog2(DefIrqPrios);

    // Context saved for an interrupted handler
    typedef struct packed {
        logic [PkgPrioWidth-1:0] level;
        logic                    nest;
    } irq_frame_t;

    localparam int unsigned FrameWidth = $bits(irq_frame_t);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACK    = 2'd1,
        SETTLE = 2'd2
    } state_e;

endpackage

// File: rtl/hetic_irq_sequencer_stack.sv
// LIFO of interrupted-handler frames; push beyond full and pop when empty are ignored.
module irq_nest_stack #(
    parameter int unsigned Depth    = 4,
    parameter int unsigned Width    = 6,
    parameter int unsigned CntWidth = $clog2(Depth + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                push_i,
    input  logic                pop_i,
    input  logic [Width-1:0]    data_i,
    output logic [Width-1:0]    top_o,
    output logic [CntWidth-1:0] count_o
);

    logic [Width-1:0]    mem_q [Depth];
    logic [CntWidth-1:0] count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_i && (count_q < CntWidth'(Depth))) begin
            for (int i = 0; i < Depth; i++) begin
                if (count_q == CntWidth'(i)) begin
                    mem_q[i] <= data_i;
                end
            end
            count_q <= count_q + CntWidth'(1);
        end else if (pop_i && (count_q != '0)) begin
            count_q <= count_q - CntWidth'(1);
        end
    end

    always_comb begin
        top_o = '0;
        for (int i = 0; i < Depth; i++) begin
            if (count_q == CntWidth'(i + 1)) begin
                top_o = mem_q[i];
            end
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/hetic_irq_sequencer.sv
// Core-side take/claim sequencer with a nesting stack that restores the
// handler level on trap return.
module hetic_irq_sequencer
    import hetic_pkg::*;
#(
    parameter int unsigned NrIrqLines = DefIrqLines,
    parameter int unsigned NrIrqPrios = DefIrqPrios,
    parameter int unsigned NestDepth  = DefNestDepth
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          irq_valid_i,
    input  logic [$clog2(NrIrqLines)-1:0] irq_id_i,
    input  logic [$clog2(NrIrqPrios)-1:0] irq_level_i,
    input  logic                          irq_heti_i,
    input  logic                          irq_nest_i,
    output logic                          irq_ack_o,
    output logic [$clog2(NrIrqLines)-1:0] irq_id_o,
    input  logic                          global_ie_i,
    input  logic                          core_ready_i,
    input  logic                          trap_done_i,
    output logic                          take_o,
    output logic [$clog2(NrIrqLines)-1:0] take_id_o,
    output logic                          take_heti_o,
    output logic [$clog2(NrIrqPrios)-1:0] cur_level_o,
    output logic [$clog2(NestDepth+1)-1:0] depth_o,
    output logic                          underflow_o
);

    localparam int unsigned IrqWidth   = $clog2(NrIrqLines);
    localparam int unsigned PrioWidth  = $clog2(NrIrqPrios);
    localparam int unsigned DepthWidth = $clog2(NestDepth + 1);

    state_e                state_q, state_d;
    logic [PrioWidth-1:0]  cur_level_q, cur_level_d;
    logic                  cur_nest_q, cur_nest_d;
    logic [IrqWidth-1:0]   id_q, id_d;
    logic                  underflow_q, underflow_d;

    logic                  push, pop, eligible;
    logic [DepthWidth-1:0] depth;
    irq_frame_t            push_frame, top_frame;

    irq_nest_stack #(
        .Depth    (NestDepth),
        .Width    (FrameWidth),
        .CntWidth (DepthWidth)
    ) u_stack (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (push_frame),
        .top_o   (top_frame),
        .count_o (depth)
    );

    assign push_frame.level = PkgPrioWidth'(cur_level_q);
    assign push_frame.nest  = cur_nest_q;

    // A return in the same cycle blocks the take; it is re-evaluated at the restored level
    assign eligible = irq_valid_i & global_ie_i & ~trap_done_i
                    & (depth < DepthWidth'(NestDepth))
                    & (irq_level_i > cur_level_q)
                    & ((depth == '0) | cur_nest_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cur_level_q <= '0;
            cur_nest_q  <= 1'b1;
            id_q        <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_level_q <= cur_level_d;
            cur_nest_q  <= cur_nest_d;
            id_q        <= id_d;
            underflow_q <= underflow_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_level_d = cur_level_q;
        cur_nest_d  = cur_nest_q;
        id_d        = id_q;
        underflow_d = underflow_q;
        push        = 1'b0;
        pop         = 1'b0;
        take_o      = 1'b0;
        irq_ack_o   = 1'b0;
        irq_id_o    = '0;

        case (state_q)
            IDLE: begin
                take_o = eligible;
                if (eligible && core_ready_i) begin
                    push        = 1'b1;
                    cur_level_d = irq_level_i;
                    cur_nest_d  = irq_nest_i;
                    id_d        = irq_id_i;
                    state_d     = ACK;
                end
            end
            ACK: begin
                irq_ack_o = 1'b1;
                irq_id_o  = id_q;
                state_d   = SETTLE;
            end
            SETTLE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Returns are honoured in every state, independent of the claim sequence
        if (trap_done_i) begin
            if (depth != '0) begin
                pop         = 1'b1;
                cur_level_d = PrioWidth'(top_frame.level);
                cur_nest_d  = top_frame.nest;
            end else begin
                underflow_d = 1'b1;
            end
        end
    end

    assign take_id_o   = irq_id_i;
    assign take_heti_o = irq_heti_i;
    assign cur_level_o = cur_level_q;
    assign depth_o     = depth;
    assign underflow_o = underflow_q;

endmodule

// File: tb/tb_hetic_irq_sequencer.sv
// Self-checking bench for hetic_irq_sequencer: per-cycle vector table plus a reset-mid-ACK sequence.
module tb_hetic_irq_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       irq_valid, irq_heti, irq_nest, global_ie, core_ready, trap_done;
    logic [5:0] irq_id;
    logic [4:0] irq_level;
    logic       irq_ack, take, take_heti, underflow;
    logic [5:0] irq_id_out, take_id;
    logic [4:0] cur_level;
    logic [2:0] depth;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    hetic_irq_sequencer dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .irq_valid_i  (irq_valid),
        .irq_id_i     (irq_id),
        .irq_level_i  (irq_level),
        .irq_heti_i   (irq_heti),
        .irq_nest_i   (irq_nest),
        .irq_ack_o    (irq_ack),
        .irq_id_o     (irq_id_out),
        .global_ie_i  (global_ie),
        .core_ready_i (core_ready),
        .trap_done_i  (trap_done),
        .take_o       (take),
        .take_id_o    (take_id),
        .take_heti_o  (take_heti),
        .cur_level_o  (cur_level),
        .depth_o      (depth),
        .underflow_o  (underflow)
    );

    typedef struct {
        logic       valid;
        logic [5:0] id;
        logic [4:0] lvl;
        logic       heti, nest, ie, rdy, td;
        logic       e_take, e_ack;
        logic [5:0] e_id;
        logic [4:0] e_lvl;
        logic [2:0] e_dep;
        logic       e_uf;
    } vec_t;

    typedef struct {
        int         idx;
        logic       take, ack;
        logic [5:0] ack_id, take_id;
        logic       heti;
        logic [4:0] lvl;
        logic [2:0] dep;
        logic       uf;
    } exp_t;

    vec_t tbl[$];
    exp_t exp_q[$];

    function automatic vec_t mk(input logic valid, input int id, input int lvl,
                                input logic heti, input logic nest, input logic ie,
                                input logic rdy, input logic td,
                                input logic e_take, input logic e_ack, input int e_id,
                                input int e_lvl, input int e_dep, input logic e_uf);
        vec_t v;
        v.valid = valid; v.id = 6'(id); v.lvl = 5'(lvl); v.heti = heti; v.nest = nest;
        v.ie = ie; v.rdy = rdy; v.td = td;
        v.e_take = e_take; v.e_ack = e_ack; v.e_id = 6'(e_id);
        v.e_lvl = 5'(e_lvl); v.e_dep = 3'(e_dep); v.e_uf = e_uf;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        if (act != req) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        irq_valid = v.valid; irq_id = v.id; irq_level = v.lvl; irq_heti = v.heti;
        irq_nest = v.nest; global_ie = v.ie; core_ready = v.rdy; trap_done = v.td;
    endtask

    task automatic compare_head();
        exp_t e;
        string tag;
        if (exp_q.size() == 0) begin
            n_miss++;
            $display("FAIL scoreboard: queue empty, expected one entry");
            return;
        end
        e = exp_q.pop_front();
        n_vec++;
        tag = $sformatf("v%0d", e.idx);
        chk({tag, ".take"}, int'(take), int'(e.take));
        chk({tag, ".ack"}, int'(irq_ack), int'(e.ack));
        if (e.ack) chk({tag, ".ack_id"}, int'(irq_id_out), int'(e.ack_id));
        chk({tag, ".take_id"}, int'(take_id), int'(e.take_id));
        chk({tag, ".take_heti"}, int'(take_heti), int'(e.heti));
        chk({tag, ".cur_level"}, int'(cur_level), int'(e.lvl));
        chk({tag, ".depth"}, int'(depth), int'(e.dep));
        chk({tag, ".underflow"}, int'(underflow), int'(e.uf));
    endtask

    initial begin
        exp_t e;
        vec_t idle_v;

        //        valid id  lvl heti nest ie rdy td | take ack aid lvl dep uf
        tbl.push_back(mk(0, 0,  0, 0, 0, 1, 1, 0,  0, 0, 0,  0, 0, 0));
        tbl.push_back(mk(1, 5,  3, 1, 1, 1, 1, 0,  1, 0, 0,  0, 0, 0)); // basic take
        tbl.push_back(mk(1, 5,  3, 1, 1, 1, 1, 0,  0, 1, 5,  3, 1, 0)); // claim
        tbl.push_back(mk(0, 0,  0, 0, 0, 1, 1, 0,  0, 0, 0,  3, 1, 0)); // settle
        tbl.push_back(mk(1, 9,  7, 0, 0, 1, 1, 0,  1, 0, 0,  3, 1, 0)); // preempt
        tbl.push_back(mk(0, 0,  0, 0, 0, 1, 1, 0,  0, 1, 9,  7, 2, 0));
        tbl.push_back(mk(0, 0,  0, 0, 0, 1, 1, 0,  0, 0, 0,  7, 2, 0));
        tbl.push_back(mk(1, 12, 20, 0, 1, 1, 1, 0, 0, 0, 0,  7, 2, 0)); // nest=0 blocks
        tbl.push_back(mk(1, 12, 20, 0, 1, 1, 1, 1, 0, 0, 0,  7, 2, 0)); // trap_done suppresses
        tbl.push_back(mk(1, 12, 20, 0, 1, 1, 1, 0, 1, 0, 0,  3, 1, 0)); // taken next cycle
        tbl.push_back(mk(0, 0,  0, 0, 0, 1, 1, 0,  0, 1, 12, 20, 2, 0));
        tbl.push_back(mk(0, 0,  0, 0, 0, 1, 1, 1,  0, 0, 0,  20, 2, 0)); // pop in SETTLE
        tbl.push_back(mk(1, 3,  3, 0, 1, 1, 1, 0,  0, 0, 0,  3, 1, 0)); // equal level
        tbl.push_back(mk(1, 3,  4, 0, 1, 1, 0, 0,  1, 0, 0,  3, 1, 0)); // core not ready
        tbl.push_back(mk(0, 0,  0, 0, 0, 1, 1, 1,  0, 0, 0,  3, 1, 0)); // pop to thread
        tbl.push_back(mk(0, 0,  0, 0, 0, 1, 1, 1,  0, 0, 0,  0, 0, 0)); // underflow
        tbl.push_back(mk(0, 0,  0, 0, 0, 1, 1, 0,  0, 0, 0,  0, 0, 1));
        tbl.push_back(mk(1, 7,  0, 0, 1, 1, 1, 0,  0, 0, 0,  0, 0, 1)); // level 0
        tbl.push_back(mk(1, 8,  5, 0, 1, 0, 1, 0,  0, 0, 0,  0, 0, 1)); // ie off
        tbl.push_back(mk(1, 1,  1, 0, 1, 1, 1, 0,  1, 0, 0,  0, 0, 1)); // fill stack
        tbl.push_back(mk(0, 0,  0, 0, 0, 1, 1, 0,  0, 1, 1,  1, 1, 1));
        tbl.push_back(mk(0, 0,  0, 0, 0, 1, 1, 0,  0, 0, 0,  1, 1, 1));
        tbl.push_back(mk(1, 2,  2, 0, 1, 1, 1, 0,  1, 0, 0,  1, 1, 1));
        tbl.push_back(mk(0, 0,  0, 0, 0, 1, 1, 0,  0, 1, 2,  2, 2, 1));
        tbl.push_back(mk(0, 0,  0, 0, 0, 1, 1, 0,  0, 0, 0,  2, 2, 1));
        tbl.push_back(mk(1, 3,  3, 0, 1, 1, 1, 0,  1, 0, 0,  2, 2, 1));
        tbl.push_back(mk(0, 0,  0, 0, 0, 1, 1, 0,  0, 1, 3,  3, 3, 1));
        tbl.push_back(mk(0, 0,  0, 0, 0, 1, 1, 0,  0, 0, 0,  3, 3, 1));
        tbl.push_back(mk(1, 4,  4, 0, 1, 1, 1, 0,  1, 0, 0,  3, 3, 1));
        tbl.push_back(mk(0, 0,  0, 0, 0, 1, 1, 0,  0, 1, 4,  4, 4, 1));
        tbl.push_back(mk(0, 0,  0, 0, 0, 1, 1, 0,  0, 0, 0,  4, 4, 1));
        tbl.push_back(mk(1, 50, 5, 1, 1, 1, 1, 0,  0, 0, 0,  4, 4, 1)); // full
        tbl.push_back(mk(1, 50, 5, 1, 1, 1, 1, 0,  0, 0, 0,  4, 4, 1));
        tbl.push_back(mk(1, 50, 5, 1, 1, 1, 1, 1,  0, 0, 0,  4, 4, 1)); // return frees a slot
        tbl.push_back(mk(1, 50, 5, 1, 1, 1, 1, 0,  1, 0, 0,  3, 3, 1));
        tbl.push_back(mk(0, 0,  0, 0, 0, 1, 1, 0,  0, 1, 50, 5, 4, 1));
        tbl.push_back(mk(0, 0,  0, 0, 0, 1, 1, 0,  0, 0, 0,  5, 4, 1));

        idle_v = mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        drive(idle_v);
        rst_n = 1'b0;
        #2;
        n_vec++;
        chk("reset.take", int'(take), 0);
        chk("reset.ack", int'(irq_ack), 0);
        chk("reset.level", int'(cur_level), 0);
        chk("reset.depth", int'(depth), 0);
        chk("reset.underflow", int'(underflow), 0);
        #10 rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            #1;
            drive(tbl[i]);
            e.idx = i; e.take = tbl[i].e_take; e.ack = tbl[i].e_ack; e.ack_id = tbl[i].e_id;
            e.take_id = tbl[i].id; e.heti = tbl[i].heti; e.lvl = tbl[i].e_lvl;
            e.dep = tbl[i].e_dep; e.uf = tbl[i].e_uf;
            exp_q.push_back(e);
            @(negedge clk);
            compare_head();
        end

        // Reset asserted in the ACK cycle drops the claim at once
        @(posedge clk);
        #1;
        drive(idle_v);
        rst_n = 1'b0;
        #1;
        n_vec++;
        chk("rst2.depth", int'(depth), 0);
        chk("rst2.underflow", int'(underflow), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        irq_valid = 1'b1; irq_id = 6'd33; irq_level = 5'd9; irq_nest = 1'b1;
        @(negedge clk);
        n_vec++;
        chk("midack.take", int'(take), 1);
        @(posedge clk);
        #1;
        n_vec++;
        chk("midack.ack", int'(irq_ack), 1);
        chk("midack.ack_id", int'(irq_id_out), 33);
        chk("midack.depth", int'(depth), 1);
        chk("midack.level", int'(cur_level), 9);
        rst_n = 1'b0;
        #1;
        n_vec++;
        chk("midack.ack_drop", int'(irq_ack), 0);
        chk("midack.depth_rst", int'(depth), 0);
        chk("midack.level_rst", int'(cur_level), 0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        chk("midack.retake", int'(take), 1);
        chk("midack.retake_id", int'(take_id), 33);

        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
